idelay_tap_loader: RTL and testbench
====================================

# idelay_tap_loader

Converts a requested fine delay in picoseconds into an IDELAYE3 tap count and loads it into the delay line. It uses the VAR_LOAD sequence: EN_VTC low, LOAD/CNTVALUEIN, settle, EN_VTC high. It is the write side of the fine-latency path: the latency calculator reads tap settings back as picoseconds, and this block turns picoseconds into taps. Ps-per-tap comes from the power-up calibration count (CNTVALUEOUTInit minus align delay); both divides share one sequential divider.

## Interface
- kCNTVALUEbit, 9, IDELAYE3 count width
- kDELAY_VALUE, 1000, calibrated delay in ps that CNTVALUEOUTInit spans
- kAlignDelay, 54, align-delay taps subtracted from CNTVALUEOUTInit
- kWidthTarget, 16, unsigned target width in ps
- kFracBits, 8, fraction bits of ps-per-tap
- kVtcWait, 10, cycles EN_VTC is held low before LOAD
- kLoadWait, 4, cycles after LOAD before EN_VTC is restored
- CLK  in  1  single clock; all logic on its rising edge
- RST_N  in  1  reset, synchronous and active-low
- CNTVALUEOUTInit  in  kCNTVALUEbit  calibration count, static during a request
- req_valid  in  1  request strobe
- req_ready  out  1  high only in IDLE
- req_target_ps  in  kWidthTarget  requested delay in ps
- CNTVALUEIN  out  kCNTVALUEbit  tap value to IDELAYE3
- LOAD  out  1  one-cycle load strobe to IDELAYE3
- EN_VTC  out  1  VT compensation enable to IDELAYE3
- done  out  1  one-cycle completion pulse
- tap_out  out  kCNTVALUEbit  tap value applied; holds until next done
- sat  out  1  target exceeded range, so the tap was clamped; valid with done
- err  out  1  invalid calibration, nothing loaded; valid with done

## Operation
- Accept a request on req_valid & req_ready and latch req_target_ps. req_valid outside IDLE is ignored, not queued.
- FSM states:
  - IDLE
  - CAL_DIV: computes tap_ps_q = (kDELAY_VALUE << kFracBits) / (CNTVALUEOUTInit − kAlignDelay), truncated.
  - TAP_DIV: computes taps = (target << kFracBits) / tap_ps_q, truncated.
  - VTC_OFF, LOAD, LOAD_WAIT, VTC_ON, DONE.
- Invalid calibration: if CNTVALUEOUTInit ≤ kAlignDelay at acceptance, go directly to DONE with err=1. IDELAYE3 outputs are untouched. tap_out keeps its previous value.
- Clamping: if taps > 2^kCNTVALUEbit − 1, clamp to 2^kCNTVALUEbit − 1 and set sat=1.
- Divider width is 24 bits (kWidthTarget + kFracBits), unsigned restoring, one quotient bit per cycle. Divisor is zero-extended.
- EN_VTC is 0 from VTC_OFF entry through the last LOAD_WAIT cycle and 1 otherwise.
- LOAD=1 only in the LOAD state, with CNTVALUEIN = taps stable from VTC_OFF entry until EN_VTC returns high.
- DONE lasts one cycle: done=1, and tap_out/sat/err are updated; then return to IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, CNTVALUEIN=0, LOAD=0, EN_VTC=1, done=0, tap_out=0, sat=0, err=0.
- Cycle schedule after a handshake at cycle T:
  - CAL_DIV: T+1..T+24
  - TAP_DIV: T+25..T+48
  - VTC_OFF: kVtcWait cycles
  - LOAD: 1 cycle
  - LOAD_WAIT: kLoadWait cycles
  - VTC_ON: 1 cycle, EN_VTC=1
  - DONE: 1 cycle
- Total latency from handshake to done is 51 + kVtcWait + kLoadWait cycles (65 at defaults). The err path gives done at T+1.
- req_ready returns high the cycle after done, so back-to-back requests are accepted then.
- Reset asserted mid-operation: at the next edge all outputs take reset values and EN_VTC goes to 1 immediately, even mid-LOAD_WAIT. The partial load is abandoned and no done is issued.
- target_ps=0 is legal: taps=0 and the full load sequence still runs.

## Structure
- Package idelay_pkg holds:
  - the FSM state enum;
  - the divider width constant (kWidthTarget + kFracBits);
  - the function for the max tap value, 2^kCNTVALUEbit − 1.
- Sub-module udiv_seq is the shared unsigned restoring divider: start, dividend, divisor in; busy, quotient, valid out.
  - Fixed 24-cycle latency; each start restarts it.
  - It is instantiated once and time-shared by CAL_DIV and TAP_DIV.

## Test plan
- CNTVALUEOUTInit=300, target=100 → tap_ps_q=1040, CNTVALUEIN=24, LOAD single pulse, done at T+65, sat=0, err=0.
- CNTVALUEOUTInit=300, target=3000 → raw 738 is clamped: tap_out=511, sat=1.
- CNTVALUEOUTInit=54, then 0 → err=1, done at T+1, LOAD never asserted, EN_VTC stays 1, tap_out unchanged.
- target=0 → CNTVALUEIN=0, and EN_VTC low for exactly kVtcWait + 1 + kLoadWait = 15 cycles.
- req_valid held high continuously with targets 100 then 200 → second accept on the cycle after the first done; tap_out 24 then 49. Requests during busy are not captured.
- RST_N low during LOAD_WAIT → next edge EN_VTC=1, LOAD=0, req_ready=1, no done. A fresh request then completes normally.

Source files
------------

// File: rtl/idelay_tap_loader_pkg.sv
// Shared types and constants for the IDELAYE3 tap loader: FSM states,
// divider width and the tap-range helper.
package idelay_pkg;

  localparam int kWidthTargetDef = 16;
  localparam int kFracBitsDef    = 8;
  localparam int kDivWidth       = kWidthTargetDef + kFracBitsDef;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAL_DIV,
    S_TAP_DIV,
    S_VTC_OFF,
    S_LOAD,
    S_LOAD_WAIT,
    S_VTC_ON,
    S_DONE
  } state_e;

  function automatic int unsigned max_tap(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/idelay_tap_loader_if.sv
// Request/response bundle between a delay requester (master) and the tap
// loader (slave).
interface idelay_tap_loader_if
  import idelay_pkg::*;
#(
  parameter int kWidthTarget = kWidthTargetDef,
  parameter int kCNTVALUEbit = 9
);

  logic                    req_valid;
  logic                    req_ready;
  logic [kWidthTarget-1:0] req_target_ps;
  logic                    done;
  logic [kCNTVALUEbit-1:0] tap_out;
  logic                    sat;
  logic                    err;

  modport master (
    output req_valid, req_target_ps,
    input  req_ready, done, tap_out, sat, err
  );

  modport slave (
    input  req_valid, req_target_ps,
    output req_ready, done, tap_out, sat, err
  );

endinterface

// File: rtl/idelay_tap_loader_udiv_seq.sv
// Unsigned restoring divider, one quotient bit per cycle. The first bit is
// resolved on the start edge, so valid pulses exactly kWidth cycles after start.
module udiv_seq
  import idelay_pkg::*;
#(
  parameter int kWidth = kDivWidth
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [kWidth-1:0] dividend,
  input  logic [kWidth-1:0] divisor,
  output logic              busy,
  output logic [kWidth-1:0] quotient,
  output logic              valid
);

  localparam int kCntW = $clog2(kWidth);

  logic [kWidth-1:0] rem_q, rem_d;
  logic [kWidth-1:0] quo_q, quo_d;
  logic [kWidth-1:0] dvs_q, dvs_d;
  logic [kCntW-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic [kWidth-1:0] step_rem;
  logic [kWidth-1:0] step_quo;
  logic [kWidth-1:0] step_dvs;
  logic [kWidth:0]   shifted;
  logic [kWidth:0]   trial;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = 1'b0;

    // A start overrides any division in flight and feeds the fresh operands in.
    step_rem = start ? '0 : rem_q;
    step_quo = start ? dividend : quo_q;
    step_dvs = start ? divisor : dvs_q;
    shifted  = {step_rem, step_quo[kWidth-1]};
    trial    = shifted - {1'b0, step_dvs};

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = kCntW'(kWidth - 1);
      dvs_d  = divisor;
    end else if (busy_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == kCntW'(1)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end

    if (start || busy_q) begin
      if (!trial[kWidth]) begin
        rem_d = trial[kWidth-1:0];
        quo_d = {step_quo[kWidth-2:0], 1'b1};
      end else begin
        rem_d = shifted[kWidth-1:0];
        quo_d = {step_quo[kWidth-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy     = busy_q;
  assign quotient = quo_q;
  assign valid    = valid_q;

endmodule

// File: rtl/idelay_tap_loader.sv
// Turns a picosecond delay request into an IDELAYE3 tap count and loads it with
// the VAR_LOAD sequence (EN_VTC low, LOAD, settle, EN_VTC high).
module idelay_tap_loader
  import idelay_pkg::*;
#(
  parameter int kCNTVALUEbit = 9,
  parameter int kDELAY_VALUE = 1000,
  parameter int kAlignDelay  = 54,
  parameter int kWidthTarget = kWidthTargetDef,
  parameter int kFracBits    = kFracBitsDef,
  parameter int kVtcWait     = 10,
  parameter int kLoadWait    = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [kCNTVALUEbit-1:0] CNTVALUEOUTInit,
  idelay_tap_loader_if.slave      req_if,
  output logic [kCNTVALUEbit-1:0] CNTVALUEIN,
  output logic                    LOAD,
  output logic                    EN_VTC
);

  localparam int kDivW = kWidthTarget + kFracBits;
  localparam int kCntW = $clog2(((kVtcWait > kLoadWait) ? kVtcWait : kLoadWait) + 1);
  localparam logic [kDivW-1:0]        kCalDividend = kDivW'(kDELAY_VALUE << kFracBits);
  localparam logic [kDivW-1:0]        kMaxTapWide  = kDivW'(max_tap(kCNTVALUEbit));
  localparam logic [kCNTVALUEbit-1:0] kMaxTap      = kCNTVALUEbit'(max_tap(kCNTVALUEbit));
  localparam logic [kCNTVALUEbit-1:0] kAlign       = kCNTVALUEbit'(kAlignDelay);

  state_e                  state_q, state_d;
  logic [kWidthTarget-1:0] target_q, target_d;
  logic [kCntW-1:0]        wait_q, wait_d;
  logic                    sat_pend_q, sat_pend_d;
  logic [kCNTVALUEbit-1:0] cntvaluein_q, cntvaluein_d;
  logic                    load_q, load_d;
  logic                    en_vtc_q, en_vtc_d;
  logic                    req_ready_q, req_ready_d;
  logic                    done_q, done_d;
  logic [kCNTVALUEbit-1:0] tap_out_q, tap_out_d;
  logic                    sat_q, sat_d;
  logic                    err_q, err_d;

  logic             div_start;
  logic [kDivW-1:0] div_dividend;
  logic [kDivW-1:0] div_divisor;
  logic             div_busy;
  logic [kDivW-1:0] div_quotient;
  logic             div_valid;
  logic             div_done;

  udiv_seq #(.kWidth(kDivW)) u_div (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .quotient (div_quotient),
    .valid    (div_valid)
  );

  assign div_done = div_valid & ~div_busy;

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    wait_d       = wait_q;
    sat_pend_d   = sat_pend_q;
    cntvaluein_d = cntvaluein_q;
    tap_out_d    = tap_out_q;
    sat_d        = sat_q;
    err_d        = err_q;
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;

    case (state_q)
      S_IDLE: begin
        if (req_if.req_valid) begin
          target_d   = req_if.req_target_ps;
          sat_pend_d = 1'b0;
          // A calibration at or below the align delay gives no usable ps/tap.
          if (CNTVALUEOUTInit <= kAlign) begin
            state_d = S_DONE;
            sat_d   = 1'b0;
            err_d   = 1'b1;
          end else begin
            state_d      = S_CAL_DIV;
            div_start    = 1'b1;
            div_dividend = kCalDividend;
            div_divisor  = kDivW'(CNTVALUEOUTInit - kAlign);
          end
        end
      end
      S_CAL_DIV: begin
        // The ps-per-tap quotient goes straight back in as the next divisor.
        if (div_done) begin
          state_d      = S_TAP_DIV;
          div_start    = 1'b1;
          div_dividend = {target_q, {kFracBits{1'b0}}};
          div_divisor  = div_quotient;
        end
      end
      S_TAP_DIV: begin
        if (div_done) begin
          state_d = S_VTC_OFF;
          wait_d  = kCntW'(kVtcWait - 1);
          if (div_quotient > kMaxTapWide) begin
            cntvaluein_d = kMaxTap;
            sat_pend_d   = 1'b1;
          end else begin
            cntvaluein_d = div_quotient[kCNTVALUEbit-1:0];
          end
        end
      end
      S_VTC_OFF: begin
        if (wait_q == '0) state_d = S_LOAD;
        else              wait_d  = wait_q - 1'b1;
      end
      S_LOAD: begin
        state_d = S_LOAD_WAIT;
        wait_d  = kCntW'(kLoadWait - 1);
      end
      S_LOAD_WAIT: begin
        if (wait_q == '0) state_d = S_VTC_ON;
        else              wait_d  = wait_q - 1'b1;
      end
      S_VTC_ON: begin
        state_d   = S_DONE;
        tap_out_d = cntvaluein_q;
        sat_d     = sat_pend_q;
        err_d     = 1'b0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned.
    req_ready_d = (state_d == S_IDLE);
    load_d      = (state_d == S_LOAD);
    en_vtc_d    = !(state_d inside {S_VTC_OFF, S_LOAD, S_LOAD_WAIT});
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      wait_q       <= '0;
      sat_pend_q   <= 1'b0;
      cntvaluein_q <= '0;
      load_q       <= 1'b0;
      en_vtc_q     <= 1'b1;
      req_ready_q  <= 1'b1;
      done_q       <= 1'b0;
      tap_out_q    <= '0;
      sat_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      wait_q       <= wait_d;
      sat_pend_q   <= sat_pend_d;
      cntvaluein_q <= cntvaluein_d;
      load_q       <= load_d;
      en_vtc_q     <= en_vtc_d;
      req_ready_q  <= req_ready_d;
      done_q       <= done_d;
      tap_out_q    <= tap_out_d;
      sat_q        <= sat_d;
      err_q        <= err_d;
    end
  end

  assign CNTVALUEIN        = cntvaluein_q;
  assign LOAD              = load_q;
  assign EN_VTC            = en_vtc_q;
  assign req_if.req_ready  = req_ready_q;
  assign req_if.done       = done_q;
  assign req_if.tap_out    = tap_out_q;
  assign req_if.sat        = sat_q;
  assign req_if.err        = err_q;

endmodule

// File: tb/tb_idelay_tap_loader.sv
// Randomized and directed bench for idelay_tap_loader against an arithmetic
// model of the ps-to-tap conversion and the load-sequence timing.
module tb_idelay_tap_loader;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [8:0] cnt_init = '0;
  logic [8:0] CNTVALUEIN;
  logic       LOAD;
  logic       EN_VTC;

  idelay_tap_loader_if #(.kWidthTarget(16), .kCNTVALUEbit(9)) req_if ();

  idelay_tap_loader dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .CNTVALUEOUTInit (cnt_init),
    .req_if          (req_if),
    .CNTVALUEIN      (CNTVALUEIN),
    .LOAD            (LOAD),
    .EN_VTC          (EN_VTC)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int last_tap = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: fixed-point ps/tap from calibration, then taps, clamped to 9 bits.
  function automatic void model(input int cnt, input int tgt,
                                output int taps, output int sat, output int err);
    int ps_per_tap;
    int raw;
    if (cnt <= 54) begin
      err  = 1;
      sat  = 0;
      taps = last_tap;
    end else begin
      ps_per_tap = (1000 * 256) / (cnt - 54);
      raw        = (tgt * 256) / ps_per_tap;
      err        = 0;
      sat        = (raw > 511) ? 1 : 0;
      taps       = (raw > 511) ? 511 : raw;
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_req(input int cnt, input int tgt, input string tag);
    int         exp_taps, exp_sat, exp_err;
    int         lat, loads, load_lat, vtc_low, unstable, ready_busy;
    logic [8:0] load_val, first_val, pre_cntin;
    model(cnt, tgt, exp_taps, exp_sat, exp_err);
    loads = 0; load_lat = 0; vtc_low = 0; unstable = 0; ready_busy = 0;
    load_val = '0; first_val = '0;
    pre_cntin = CNTVALUEIN;
    cnt_init = 9'(cnt);
    req_if.req_target_ps = 16'(tgt);
    req_if.req_valid = 1'b1;
    check({tag, "/ready_at_accept"}, longint'(req_if.req_ready), 1);
    tick();
    req_if.req_valid = 1'b0;
    req_if.req_target_ps = 16'($urandom_range(0, 65535));
    lat = 1;
    while (lat <= 200) begin
      if (LOAD) begin
        loads++;
        load_lat = lat;
        load_val = CNTVALUEIN;
      end
      if (!EN_VTC) begin
        if (vtc_low == 0) first_val = CNTVALUEIN;
        else if (CNTVALUEIN != first_val) unstable++;
        vtc_low++;
      end
      if (req_if.req_ready) ready_busy++;
      if (req_if.done) break;
      tick();
      lat++;
    end
    check({tag, "/latency"}, lat, (exp_err != 0) ? 1 : 65);
    check({tag, "/tap_out"}, longint'(req_if.tap_out), exp_taps);
    check({tag, "/sat"}, longint'(req_if.sat), exp_sat);
    check({tag, "/err"}, longint'(req_if.err), exp_err);
    check({tag, "/cntvaluein"}, longint'(CNTVALUEIN), (exp_err != 0) ? longint'(pre_cntin) : exp_taps);
    check({tag, "/load_pulses"}, loads, (exp_err != 0) ? 0 : 1);
    check({tag, "/load_cycle"}, load_lat, (exp_err != 0) ? 0 : 59);
    check({tag, "/load_value"}, longint'(load_val), (exp_err != 0) ? 0 : exp_taps);
    check({tag, "/vtc_low_cycles"}, vtc_low, (exp_err != 0) ? 0 : 15);
    check({tag, "/cntvaluein_stable"}, unstable, 0);
    check({tag, "/ready_while_busy"}, ready_busy, 0);
    $display("txn %s cnt=%0d target=%0d tap_out=%0d sat=%0d err=%0d latency=%0d",
             tag, cnt, tgt, req_if.tap_out, req_if.sat, req_if.err, lat);
    tick();
    check({tag, "/done_one_cycle"}, longint'(req_if.done), 0);
    check({tag, "/ready_after_done"}, longint'(req_if.req_ready), 1);
    if (exp_err == 0) last_tap = exp_taps;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/req_ready"}, longint'(req_if.req_ready), 1);
    check({tag, "/EN_VTC"}, longint'(EN_VTC), 1);
    check({tag, "/LOAD"}, longint'(LOAD), 0);
    check({tag, "/done"}, longint'(req_if.done), 0);
    check({tag, "/CNTVALUEIN"}, longint'(CNTVALUEIN), 0);
    check({tag, "/tap_out"}, longint'(req_if.tap_out), 0);
    check({tag, "/sat"}, longint'(req_if.sat), 0);
    check({tag, "/err"}, longint'(req_if.err), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, first_lat, second_lat, ready_cnt, done_cnt, cnt, tgt;
    req_if.req_valid = 1'b0;
    req_if.req_target_ps = '0;
    RST_N = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    RST_N = 1'b1;
    tick();

    run_req(300, 100, "base");
    run_req(300, 3000, "clamp");
    run_req(54, 500, "err54");
    run_req(0, 500, "err0");
    run_req(300, 0, "zero");

    // req_valid held high; the target change while busy must be ignored.
    cnt_init = 9'd300;
    req_if.req_target_ps = 16'd100;
    req_if.req_valid = 1'b1;
    tick();
    req_if.req_target_ps = 16'd200;
    lat = 1; first_lat = 0; second_lat = 0; ready_cnt = 0;
    while (lat <= 300) begin
      if (req_if.req_ready) ready_cnt++;
      if (req_if.done) begin
        if (first_lat == 0) begin
          first_lat = lat;
          check("b2b/first_tap", longint'(req_if.tap_out), 24);
        end else begin
          second_lat = lat;
          check("b2b/second_tap", longint'(req_if.tap_out), 49);
          break;
        end
      end
      tick();
      lat++;
    end
    req_if.req_valid = 1'b0;
    check("b2b/first_done", first_lat, 65);
    check("b2b/second_done", second_lat, 131);
    check("b2b/ready_cycles", ready_cnt, 1);
    $display("txn b2b targets=100,200 first_done=%0d second_done=%0d", first_lat, second_lat);
    last_tap = 49;
    tick();

    // Reset in the middle of LOAD_WAIT abandons the load.
    cnt_init = 9'd300;
    req_if.req_target_ps = 16'd100;
    req_if.req_valid = 1'b1;
    tick();
    req_if.req_valid = 1'b0;
    lat = 1;
    while (lat < 61) begin
      tick();
      lat++;
    end
    check("rst/en_vtc_low_before", longint'(EN_VTC), 0);
    RST_N = 1'b0;
    tick();
    check_reset_outputs("rst_mid_load");
    last_tap = 0;
    RST_N = 1'b1;
    done_cnt = 0;
    repeat (80) begin
      tick();
      if (req_if.done) done_cnt++;
    end
    check("rst/no_done", done_cnt, 0);
    $display("txn reset_mid_load_wait done_after=%0d", done_cnt);
    run_req(300, 200, "after_rst");

    for (int i = 0; i < 24; i++) begin
      cnt = (i % 4 == 0) ? int'($urandom_range(40, 70)) : int'($urandom_range(0, 511));
      tgt = (i % 3 == 0) ? int'($urandom_range(0, 600)) : int'($urandom_range(0, 65535));
      run_req(cnt, tgt, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
